// File: rtl/clk_ctrl_pkg.sv
// Shared types for the CPU clock-control slice: FSM state encoding.
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, counter debounce and a
// one-cycle press pulse on the debounced rising edge.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 8,
    parameter int unsigned DB_W      = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic press
);

    logic            sync1_q;
    logic            sync2_q;
    logic            btn_st_q;
    logic            btn_prev_q;
    logic            armed_q;
    logic [1:0]      live_q;
    logic [DB_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            btn_st_q   <= 1'b0;
            btn_prev_q <= 1'b0;
            armed_q    <= 1'b0;
            live_q     <= 2'b00;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= btn_in;
            sync2_q    <= sync1_q;
            btn_prev_q <= btn_st_q;
            // live_q[1] marks sync2_q as holding a real sample, not a reset value
            live_q     <= {live_q[0], 1'b1};
            // A button held through reset must be seen released before it may step
            if (live_q[1] && !sync2_q && !btn_st_q) begin
                armed_q <= 1'b1;
            end
            if (sync2_q != btn_st_q) begin
                if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
                    btn_st_q <= sync2_q;
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + DB_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign press = btn_st_q & ~btn_prev_q & armed_q;

endmodule

// File: rtl/clk_step_ctrl.sv
// CPU clock-enable controller: free-run on the divider tick, single-step on a
// debounced button press, or halted; counts issued enables.
module clk_step_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 8,
    parameter int unsigned DB_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_10,
    input  logic        mode,
    input  logic        step_btn,
    input  logic        halt,
    output logic        cpu_en,
    output logic [1:0]  state,
    output logic [15:0] step_cnt
);

    logic        mode_sync1_q;
    logic        mode_sync2_q;
    logic        press;
    state_t      state_q;
    state_t      state_d;
    logic        cpu_en_q;
    logic        cpu_en_d;
    logic [15:0] step_cnt_q;

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES),
        .DB_W     (DB_W)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn_in(step_btn),
        .press (press)
    );

    // Pulse decision uses the current state; a coincident mode change lands afterwards
    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = mode_sync2_q ? ST_STEP : ST_RUN;
            end
            ST_RUN: begin
                cpu_en_d = tick_10 & ~halt;
                if (halt) begin
                    state_d = ST_HALTED;
                end else if (mode_sync2_q) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                cpu_en_d = press & ~halt;
                if (halt) begin
                    state_d = ST_HALTED;
                end else if (!mode_sync2_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (!halt && press) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_sync1_q <= 1'b0;
            mode_sync2_q <= 1'b0;
            state_q      <= ST_IDLE;
            cpu_en_q     <= 1'b0;
            step_cnt_q   <= 16'h0000;
        end else begin
            mode_sync1_q <= mode;
            mode_sync2_q <= mode_sync1_q;
            state_q      <= state_d;
            cpu_en_q     <= cpu_en_d;
            step_cnt_q   <= step_cnt_q + 16'(cpu_en_d);
        end
    end

    assign cpu_en   = cpu_en_q;
    assign state    = state_q;
    assign step_cnt = step_cnt_q;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Scoreboard bench for clk_step_ctrl: expected enable pulses are queued as
// stimulus is driven and matched against cpu_en as it appears.
module tb_clk_step_ctrl;
    import clk_ctrl_pkg::*;

    localparam int unsigned DbCycles = 8;
    localparam int unsigned PressLat = DbCycles + 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_10 = 1'b0;
    logic        mode = 1'b0;
    logic        step_btn = 1'b0;
    logic        halt = 1'b0;
    logic        cpu_en;
    logic [1:0]  state;
    logic [15:0] step_cnt;

    typedef struct {
        int unsigned cyc;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] exp_cnt = 16'h0000;
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    clk_step_ctrl #(
        .DB_CYCLES(DbCycles),
        .DB_W     (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tick_10 (tick_10),
        .mode    (mode),
        .step_btn(step_btn),
        .halt    (halt),
        .cpu_en  (cpu_en),
        .state   (state),
        .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_pulse(input int unsigned delay);
        exp_t e;
        exp_cnt = exp_cnt + 16'h0001;
        e.cyc = cyc + delay;
        e.cnt = exp_cnt;
        exp_q.push_back(e);
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_tick(input bit want_en);
        @(negedge clk);
        tick_10 = 1'b1;
        if (want_en) expect_pulse(1);
        @(negedge clk);
        tick_10 = 1'b0;
    endtask

    // Every cpu_en pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (cpu_en === 1'b1) begin
            check("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_cnt", 32'(step_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        // Reset then run
        wait_cycles(3);
        check("rst_cpu_en", 32'(cpu_en), 32'd0);
        check("rst_state", 32'(state), 32'(ST_IDLE));
        check("rst_step_cnt", 32'(step_cnt), 32'd0);
        rst = 1'b0;
        wait_cycles(5);
        check("run_state", 32'(state), 32'(ST_RUN));
        for (int i = 0; i < 5; i++) begin
            pulse_tick(1'b1);
            wait_cycles(8);
        end
        check("run_step_cnt", 32'(step_cnt), 32'd5);
        check("run_queue_empty", exp_q.size(), 0);

        // Step with bounce; ticks ignored in STEP
        mode = 1'b1;
        wait_cycles(5);
        check("step_state", 32'(state), 32'(ST_STEP));
        for (int i = 0; i < 3; i++) begin
            step_btn = 1'b1;
            wait_cycles(2);
            step_btn = 1'b0;
            wait_cycles(2);
        end
        pulse_tick(1'b0);
        @(negedge clk);
        step_btn = 1'b1;
        expect_pulse(PressLat);
        wait_cycles(5);
        pulse_tick(1'b0);
        wait_cycles(13);
        step_btn = 1'b0;
        wait_cycles(DbCycles + 6);
        check("step_step_cnt", 32'(step_cnt), 32'd6);
        check("step_queue_empty", exp_q.size(), 0);

        // Halt priority over a coincident tick
        mode = 1'b0;
        wait_cycles(5);
        check("halt_pre_state", 32'(state), 32'(ST_RUN));
        @(negedge clk);
        tick_10 = 1'b1;
        halt = 1'b1;
        @(negedge clk);
        tick_10 = 1'b0;
        halt = 1'b0;
        check("halt_cpu_en", 32'(cpu_en), 32'd0);
        check("halt_state", 32'(state), 32'(ST_HALTED));
        pulse_tick(1'b0);
        wait_cycles(3);
        check("halt_hold_state", 32'(state), 32'(ST_HALTED));
        @(negedge clk);
        step_btn = 1'b1;
        wait_cycles(PressLat);
        check("halt_to_idle", 32'(state), 32'(ST_IDLE));
        @(negedge clk);
        check("idle_to_run", 32'(state), 32'(ST_RUN));
        wait_cycles(10);
        step_btn = 1'b0;
        wait_cycles(DbCycles + 6);
        check("halt_step_cnt", 32'(step_cnt), 32'd6);

        // Counter wrap
        @(negedge clk);
        force dut.step_cnt_q = 16'hFFFE;
        exp_cnt = 16'hFFFE;
        #1;
        release dut.step_cnt_q;
        check("wrap_preset", 32'(step_cnt), 32'h0000_FFFE);
        pulse_tick(1'b1);
        wait_cycles(3);
        check("wrap_ffff", 32'(step_cnt), 32'h0000_FFFF);
        pulse_tick(1'b1);
        wait_cycles(3);
        check("wrap_zero", 32'(step_cnt), 32'h0000_0000);
        pulse_tick(1'b1);
        wait_cycles(3);
        check("wrap_queue_empty", exp_q.size(), 0);

        // Reset mid-debounce with the button held
        mode = 1'b1;
        wait_cycles(5);
        check("rst2_pre_state", 32'(state), 32'(ST_STEP));
        @(negedge clk);
        step_btn = 1'b1;
        wait_cycles(7);
        check("rst2_db_cnt", 32'(dut.u_debounce.cnt_q), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        check("rst2_cpu_en", 32'(cpu_en), 32'd0);
        check("rst2_state", 32'(state), 32'(ST_IDLE));
        check("rst2_step_cnt", 32'(step_cnt), 32'd0);
        rst = 1'b0;
        exp_cnt = 16'h0000;
        wait_cycles(30);
        check("rst2_held_state", 32'(state), 32'(ST_STEP));
        check("rst2_held_cnt", 32'(step_cnt), 32'd0);
        step_btn = 1'b0;
        wait_cycles(DbCycles + 6);
        @(negedge clk);
        step_btn = 1'b1;
        expect_pulse(PressLat);
        wait_cycles(20);
        step_btn = 1'b0;
        wait_cycles(DbCycles + 6);
        check("rst2_repress_cnt", 32'(step_cnt), 32'd1);
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_step_ctrl.md
# clk_step_ctrl

Clock-control stage directly downstream of the 1:10 clock divider. It turns the divider's slow tick, or a debounced single-step push-button, into a one-cycle CPU clock-enable (`cpu_en`) for the single-cycle datapath. It supports free-run, single-step and halted operation, and counts issued steps for display. Everything runs on the board clock; the divided rate reaches this block as a one-cycle enable pulse, not as a separate clock.

## Interface
Parameters:
- `DB_CYCLES`, default 8: consecutive stable cycles required to accept a button level change.
- `DB_W`, default 4: width of the debounce counter; must satisfy 2^DB_W > DB_CYCLES.

Ports:
- `clk` in 1: board clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `tick_10` in 1: one-cycle pulse from the 1:10 divider, synchronous to `clk`.
- `mode` in 1: slide switch, asynchronous; 0 = run, 1 = step.
- `step_btn` in 1: raw push-button, asynchronous, bouncy.
- `halt` in 1: halt request from the CPU, synchronous to `clk`.
- `cpu_en` out 1: registered one-cycle enable to the CPU.
- `state` out 2: current FSM state.
- `step_cnt` out 16: number of `cpu_en` pulses issued.

## Operation
- **Synchronisers:** `mode` and `step_btn` each pass through a 2-flop synchroniser. `mode` is not debounced.
- **Debounce:**
  - Hold a stable level `btn_st` and a counter.
  - When the synchronised level differs from `btn_st`, increment the counter.
  - On the DB_CYCLES-th consecutive mismatch, set `btn_st` to the synchronised level and clear the counter.
  - Any matching cycle clears the counter.
  - `press` = `btn_st` rising (combinational against a 1-cycle delayed copy).
- **FSM states:** IDLE=2'b00, RUN=2'b01, STEP=2'b10, HALTED=2'b11.
- **Transitions:**
  - IDLE: go to RUN if synchronised mode=0, else go to STEP.
  - RUN: on `halt`, go to HALTED. Otherwise, if mode=1, go to STEP.
  - STEP: on `halt`, go to HALTED. Otherwise, if mode=0, go to RUN.
  - HALTED: go to IDLE when `halt`=0 and `press`=1; otherwise stay.
- **Enable generation:**
  - In RUN, `tick_10` sets `cpu_en` at the next edge.
  - In STEP, `press` sets `cpu_en` at the next edge.
  - IDLE and HALTED never issue `cpu_en`.
- **Simultaneous events:**
  - `halt` suppresses any pulse in the same cycle.
  - When a mode change coincides with a qualifying tick or press, the pulse is issued based on the current state, then the state changes.
  - A `press` in RUN is ignored. A `tick_10` in STEP is ignored.
- **step_cnt:** increments on each cycle where `cpu_en` is set. It wraps from 16'hFFFF to 16'h0000.

## Timing
- **Reset values:** `cpu_en`=0, `state`=IDLE, `step_cnt`=0. Synchronisers, `btn_st`, its delayed copy and the debounce counter all reset to 0.
- **Reset mid-operation:** the next cycle is fully in the reset state. A held button then needs a full re-debounce; it gives no pulse until it is released and pressed again.
- **RUN latency:** `tick_10` high in cycle n gives `cpu_en` high in cycle n+1, for exactly 1 cycle.
- **STEP latency:** `step_btn` first sampled high at edge k gives `cpu_en` high after edge k+DB_CYCLES+2, for exactly one cycle.
- **Bounce rejection:** a glitch shorter than DB_CYCLES cycles produces no pulse. A press held indefinitely produces exactly one pulse.
- **Mode change:** takes effect 2 cycles after the switch change, plus 1 cycle for the state update.
- **Step rate:** at most one `cpu_en` per `tick_10` or per press. `cpu_en` is never high on two consecutive cycles.

## Structure
- Package `clk_ctrl_pkg`: the state encoding constants `ST_IDLE`, `ST_RUN`, `ST_STEP`, `ST_HALTED`, and the 2-bit state type.
- Sub-module `btn_debounce` (params `DB_CYCLES`, `DB_W`; ports `clk`, `rst`, `btn_in` in, `press` out). It contains the synchroniser, counter and edge detect.
- Top-level `clk_step_ctrl` instantiates `btn_debounce`, adds the mode synchroniser, the FSM, `cpu_en` generation and `step_cnt`.

## Test plan
- **Reset then run:** reset, hold `mode`=0, drive `tick_10` pulses every 10 cycles × 5 → state=RUN; 5 `cpu_en` pulses, each 1 cycle after its tick; `step_cnt`=5.
- **Step with bounce:** set `mode`=1; toggle `step_btn` 3 times with 2-cycle glitches, then hold high 20 cycles (DB_CYCLES=8) → exactly 1 `cpu_en`, 10 edges after the first steady-high sampling edge; `tick_10` pulses ignored.
- **Halt priority:** in RUN, assert `halt` in the same cycle as `tick_10` → no `cpu_en`; state=HALTED. Deassert `halt` and press → state=IDLE, then RUN/STEP per `mode`.
- **Wrap:** force `step_cnt` to 16'hFFFE; issue 2 ticks → 16'hFFFF, then 16'h0000.
- **Reset mid-step:** assert `rst` while the debounce counter is at 5 with the button held → next cycle `cpu_en`=0, state=IDLE, `step_cnt`=0; no pulse until the button is released and re-pressed.
